dram_bucket_assembler: RTL
==========================

# dram_bucket_assembler

Downstream stage of the ASIC dummy DRAM read-data generator and of the real DDR3 read path. It collects the BEDWidth-wide read chunks of one ORAM bucket into a full bucket, then decodes the bucket header: IV, per-slot valid bits, program addresses and leaves. Finished buckets go to the backend over a valid/ready handshake. The DRAM side cannot be stalled, so the block holds two buckets and reports overflow rather than stalling.

## Interface
- BEDWidth, 512, DRAM read chunk width in bits
- NChunks, 6, chunks per bucket (BktSize_BEDChunks)
- ORAMZ, 4, block slots per bucket
- ORAMU, 32, program-address width per slot
- ORAML, 32, leaf width per slot
- AESEntropy, 64, IV width at bucket bit 0
- BktHVStart, 64, first valid bit; slot i valid at BktHVStart+i
- BktHUStart, 96, slot i address at BktHUStart+i*ORAMU
- BktHLStart, 224, slot i leaf at BktHLStart+i*ORAML

Ports:
- Clock  in  1  sole clock; everything is synchronous to its rising edge
- Reset  in  1  synchronous, active-high
- DRAMReadData  in  BEDWidth  read chunk
- DRAMReadDataValid  in  1  chunk present this cycle; always accepted, no backpressure
- BucketData  out  NChunks*BEDWidth  assembled bucket; chunk k at bits [(k+1)*BEDWidth-1 : k*BEDWidth]
- BucketIV  out  AESEntropy  BucketData[AESEntropy-1:0]
- BucketValidBits  out  ORAMZ  header valid bits
- BucketPAddr  out  ORAMZ*ORAMU  slot addresses
- BucketLeaf  out  ORAMZ*ORAML  slot leaves
- BucketOutValid  out  1  head bucket available
- BucketOutReady  in  1  consumer accepts head bucket
- ChunkIndex  out  log2(NChunks)  index of the next chunk expected
- Overflow  out  1  sticky; a completed bucket was dropped
- BucketsSeen  out  32  count of completed buckets, saturates at 2^32-1

## Operation
- Chunk counter cnt runs 0..NChunks-1. On each DRAMReadDataValid, the chunk is written to slice cnt of the assembly register. cnt then increments, or wraps to 0 when cnt == NChunks-1.
- A bucket completes when the chunk arrives with cnt == NChunks-1. The full bucket (the assembly register with the final slice replaced by the incoming chunk) is pushed into a 2-entry FIFO.
- Each bucket completion increments BucketsSeen, including dropped buckets.
- The FIFO head drives BucketData. Header fields are pure slices of the head entry, with no extra pipeline stage.
- Pop happens when BucketOutValid && BucketOutReady.
- Push while FIFO full and no pop in the same cycle: the bucket is dropped, Overflow is set, and FIFO contents are unchanged.
- Push while full with a simultaneous pop: the push is accepted and occupancy stays 2.
- Push while empty: BucketOutValid rises the next cycle. Data does not bypass into the same cycle.
- Overflow clears only on Reset.
- FIFO states: EMPTY (occ 0) -> ONE on push. ONE -> TWO on push without pop. ONE -> EMPTY on pop without push. ONE stays ONE on push+pop. TWO -> ONE on pop without push. TWO stays TWO on push+pop, or on a drop.

## Timing
- Reset values: BucketOutValid 0, Overflow 0, BucketsSeen 0, ChunkIndex 0. BucketData and the header outputs are 0 (storage cleared).
- Latency: final chunk at cycle t -> BucketOutValid = 1 at t+1 with the correct data, provided the FIFO was empty.
- Chunk-to-chunk gaps are arbitrary and do not reset cnt. Only Reset discards a partial bucket.
- Reset mid-bucket: partial data is lost, cnt returns to 0, and the next valid chunk is chunk 0.
- BucketData and header fields remain stable while BucketOutValid && !BucketOutReady.
- Peak throughput: one bucket per NChunks cycles with continuous valid and ready held high. No drops occur in that case.

## Structure
- Shared package bucket_pkg holds the bucket field offsets (BktHVStart, BktHUStart, BktHLStart, AESEntropy) and a BucketWidth = NChunks*BEDWidth constant. The DRAM generators and this block use the same definitions.
- Sub-module bucket_fifo2: 2-entry, BucketWidth-wide register FIFO with push, pop, full, empty and head outputs. It has no bypass; the block's drop and push+pop-when-full rules are implemented inside it.
- Top level contains the chunk counter, the assembly register, the statistics counter, and the header slicing.

## Test plan
- Reset, then 6 valid chunks with values 0x1..0x6 on consecutive cycles, ready held 1 -> BucketOutValid for exactly one cycle at t+1; chunk k of BucketData = k+1; BucketsSeen = 1.
- Bucket with bits [67:64] = 4'b1100 and slot 2 address 0x15 -> BucketValidBits = 4'b1100, BucketPAddr[95:64] = 0x15, BucketIV = bucket bits [63:0].
- Ready = 0, push three buckets -> first two are held in order, Overflow = 1 after the third, BucketsSeen = 3. Then raise ready -> buckets 1 and 2 pop in order, and BucketOutValid returns to 0.
- FIFO full, final chunk arrives in the same cycle as a pop -> no drop, Overflow stays 0, occupancy stays 2, new bucket emitted third.
- 3 chunks, Reset pulse, then 6 chunks -> one bucket containing only the post-reset chunks; ChunkIndex = 0 immediately after reset.
- Random gaps of 0–5 cycles between chunks, ready toggling at random, 1000 buckets with no overflow -> buckets emitted in order and bit-exact against a scoreboard.

Source files
------------

// File: rtl/bucket_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bucket_pkg: ORAM bucket geometry and header offsets shared by DRAM-side blocks
// Rev 1.0
// ---------------------------------------------------------------------------
package bucket_pkg;

  localparam int BEDWidth      = 512;
  localparam int NChunks       = 6;
  localparam int ORAMZ         = 4;
  localparam int ORAMU         = 32;
  localparam int ORAML         = 32;
  localparam int AESEntropy    = 64;
  localparam int BktHVStart    = 64;
  localparam int BktHUStart    = 96;
  localparam int BktHLStart    = 224;
  localparam int BucketWidth   = NChunks * BEDWidth;
  localparam int ChunkIdxWidth = $clog2(NChunks);

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_e;

endpackage
`default_nettype wire

// File: rtl/bucket_fifo2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bucket_fifo2: 2-entry bucket register FIFO; a push into a full FIFO without pop is ignored
// Rev 1.0
// ---------------------------------------------------------------------------
module bucket_fifo2
  import bucket_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [BucketWidth-1:0] push_data,
  input  logic                   pop,
  output logic [BucketWidth-1:0] head,
  output logic                   full,
  output logic                   empty
);

  fifo_state_e            state;
  logic [BucketWidth-1:0] tail;
  logic                   do_pop;

  assign do_pop = pop && (state != FIFO_EMPTY);
  assign full   = (state == FIFO_TWO);
  assign empty  = (state == FIFO_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FIFO_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        FIFO_EMPTY: begin
          if (push) begin
            head  <= push_data;
            state <= FIFO_ONE;
          end
        end
        FIFO_ONE: begin
          if (push && do_pop) begin
            head <= push_data;
          end else if (push) begin
            tail  <= push_data;
            state <= FIFO_TWO;
          end else if (do_pop) begin
            state <= FIFO_EMPTY;
          end
        end
        FIFO_TWO: begin
          // Without a pop, a push here is a drop: contents stay untouched.
          if (do_pop) begin
            head <= tail;
            if (push) tail <= push_data;
            else      state <= FIFO_ONE;
          end
        end
        default: state <= FIFO_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_bucket_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dram_bucket_assembler: gathers DRAM read chunks into ORAM buckets and decodes the header
// Rev 1.0
// ---------------------------------------------------------------------------
module dram_bucket_assembler
  import bucket_pkg::*;
(
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [BEDWidth-1:0]      DRAMReadData,
  input  logic                     DRAMReadDataValid,
  output logic [BucketWidth-1:0]   BucketData,
  output logic [AESEntropy-1:0]    BucketIV,
  output logic [ORAMZ-1:0]         BucketValidBits,
  output logic [ORAMZ*ORAMU-1:0]   BucketPAddr,
  output logic [ORAMZ*ORAML-1:0]   BucketLeaf,
  output logic                     BucketOutValid,
  input  logic                     BucketOutReady,
  output logic [ChunkIdxWidth-1:0] ChunkIndex,
  output logic                     Overflow,
  output logic [31:0]              BucketsSeen
);

  logic [ChunkIdxWidth-1:0]        cnt;
  logic [(NChunks-1)*BEDWidth-1:0] assembly;
  logic [BucketWidth-1:0]          bucket_in;
  logic                            last_chunk;
  logic                            push;
  logic                            pop;
  logic                            fifo_full;
  logic                            fifo_empty;

  assign last_chunk = (cnt == ChunkIdxWidth'(NChunks - 1));
  assign push       = DRAMReadDataValid && last_chunk;
  assign pop        = BucketOutValid && BucketOutReady;
  // The final chunk goes straight into the FIFO, so it never needs an assembly slot.
  assign bucket_in  = {DRAMReadData, assembly};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (DRAMReadDataValid) begin
      cnt <= last_chunk ? '0 : cnt + ChunkIdxWidth'(1);
    end
  end

  for (genvar k = 0; k < NChunks - 1; k++) begin : g_slice
    always_ff @(posedge Clock) begin
      if (Reset) begin
        assembly[k*BEDWidth +: BEDWidth] <= '0;
      end else if (DRAMReadDataValid && (cnt == ChunkIdxWidth'(k))) begin
        assembly[k*BEDWidth +: BEDWidth] <= DRAMReadData;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      BucketsSeen <= '0;
      Overflow    <= 1'b0;
    end else begin
      if (push && (BucketsSeen != '1)) BucketsSeen <= BucketsSeen + 32'd1;
      if (push && fifo_full && !pop)   Overflow    <= 1'b1;
    end
  end

  bucket_fifo2 u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (push),
    .push_data (bucket_in),
    .pop       (pop),
    .head      (BucketData),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign BucketOutValid  = !fifo_empty;
  assign ChunkIndex      = cnt;
  assign BucketIV        = BucketData[AESEntropy-1:0];
  assign BucketValidBits = BucketData[BktHVStart +: ORAMZ];

  for (genvar i = 0; i < ORAMZ; i++) begin : g_slot
    assign BucketPAddr[i*ORAMU +: ORAMU] = BucketData[BktHUStart + i*ORAMU +: ORAMU];
    assign BucketLeaf[i*ORAML +: ORAML]  = BucketData[BktHLStart + i*ORAML +: ORAML];
  end

endmodule
`default_nettype wire
